uart_tx_sched: RTL and testbench

Round-robin scheduler sharing a single `uart_tx` serializer among `N_REQ` byte producers. It arbitrates among pending requests, captures the winner's byte, issues a one-cycle load to the transmitter, and holds off further grants until the transmitter reports frame completion. It sits directly in front of `uart_tx` and drives its `tx_byte`/`load` inputs from its `tx_done` output.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 43 ++++
 rtl/uart_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler slice.
// Scheduler state encodings, frame-bit constants and a ceil-log2 helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;

    // Ceil(log2(v)), never below 1 so the result is a usable vector width.
    function automatic int clogb2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) begin
            n++;
        end
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: picks the first set request bit
// searching upward from ptr+1 and wrapping around.
// Ports: req (request vector), ptr (last winner),
//        gnt_onehot / gnt_idx (winner), any (some request set).
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [clogb2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt_onehot,
    output logic [clogb2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int IW = clogb2(N_REQ);

    logic hit;

    // First pass covers indices above ptr, second pass wraps to 0..ptr.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        hit        = 1'b0;
        any        = |req;
        for (int i = 0; i < N_REQ; i++) begin
            if (!hit && req[i] && (i > int'(ptr))) begin
                hit           = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!hit && req[i] && (i <= int'(ptr))) begin
                hit           = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// Ports: clk, rst (async, active-high); req_valid/req_data/req_ready
//        requester side; tx_byte/tx_load/tx_done serializer side;
//        busy, grant_id, timeout_err status.
// Optional WAIT watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WORD_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*WORD_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [WORD_WIDTH-1:0]       tx_byte,
    output logic                        tx_load,
    input  logic                        tx_done,
    output logic                        busy,
    output logic [clogb2(N_REQ)-1:0]    grant_id,
    output logic                        timeout_err
);

    localparam int IW = clogb2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("uart_tx_sched: N_REQ must be 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_sched: TIMEOUT_CYCLES must be positive");
    end

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [WORD_WIDTH-1:0] byte_q, byte_d;
    logic                  load_q, load_d;
    logic [N_REQ-1:0]      rdy_q, rdy_d;
    logic                  busy_q;

    logic [N_REQ-1:0]      pick_oh;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic [WORD_WIDTH-1:0] sel_byte;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (pick_oh),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_byte = req_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = clogb2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic          terr_q, terr_d;

    assign cnt_nxt = cnt_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        load_d  = 1'b0;
        rdy_d   = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_LOAD;
                    ptr_d   = pick_idx;
                    byte_d  = sel_byte;
                    load_d  = 1'b1;
                    rdy_d   = pick_oh;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                // A coinciding tx_done takes priority over the limit.
                else if (cnt_nxt == CW'(TIMEOUT_CYCLES)) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_nxt;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            byte_q  <= '0;
            load_q  <= 1'b0;
            rdy_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
            load_q  <= load_d;
            rdy_q   <= rdy_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready = rdy_q;
    assign tx_byte   = byte_q;
    assign tx_load   = load_q;
    assign busy      = busy_q;
    assign grant_id  = ptr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table-driven vectors plus
// hand-written sequences for round-robin, withdraw, reset and watchdog.
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int W = 8;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO       = 16;
    localparam int DONE_DLY = 10;
`else
    localparam int TO       = 256;
    localparam int DONE_DLY = 100;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_byte;
    logic           tx_load;
    logic           tx_done;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    uart_tx_sched #(
        .N_REQ          (N),
        .WORD_WIDTH     (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        done;
        logic [3:0]  rdy;
        logic        load;
        logic        bsy;
        logic [1:0]  gid;
        logic [7:0]  byt;
    } vec_t;

    localparam logic [31:0] DA = 32'h0000_00A5;
    localparam logic [31:0] DD = 32'h1312_1110;

    vec_t tv[12];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d,
                                input logic dn, input logic [3:0] r,
                                input logic l, input logic b,
                                input logic [1:0] g, input logic [7:0] y);
        vec_t t;
        t.valid = v;
        t.data  = d;
        t.done  = dn;
        t.rdy   = r;
        t.load  = l;
        t.bsy   = b;
        t.gid   = g;
        t.byt   = y;
        return t;
    endfunction

    task automatic do_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int frames;
        int pulses;
        int dcnt;
        logic seen2;
        logic terr_seen;

        // inputs applied before an edge, outputs expected after it
        tv[0]  = mk(4'b0000, DA, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00);
        tv[1]  = mk(4'b0000, DA, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00);
        tv[2]  = mk(4'b0001, DA, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hA5);
        tv[3]  = mk(4'b0000, DA, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5);
        tv[4]  = mk(4'b0000, DA, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5);
        tv[5]  = mk(4'b0010, DD, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5);
        tv[6]  = mk(4'b0010, DD, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA5);
        tv[7]  = mk(4'b0010, DD, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11);
        tv[8]  = mk(4'b0000, DD, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h11);
        tv[9]  = mk(4'b1111, DD, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h11);
        tv[10] = mk(4'b1111, DD, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h12);
        tv[11] = mk(4'b0000, DD, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'h12);

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.ready", 32'(req_ready), 32'h0);
        chk("reset.load", 32'(tx_load), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        chk("reset.gid", 32'(grant_id), 32'h3);
        chk("reset.byte", 32'(tx_byte), 32'h0);
        chk("reset.terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            req_valid = tv[i].valid;
            req_data  = tv[i].data;
            tx_done   = tv[i].done;
            @(negedge clk);
            chk($sformatf("row%0d.ready", i), 32'(req_ready), 32'(tv[i].rdy));
            chk($sformatf("row%0d.load", i), 32'(tx_load), 32'(tv[i].load));
            chk($sformatf("row%0d.busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("row%0d.gid", i), 32'(grant_id), 32'(tv[i].gid));
            chk($sformatf("row%0d.byte", i), 32'(tx_byte), 32'(tv[i].byt));
            chk($sformatf("row%0d.terr", i), 32'(timeout_err), 32'h0);
        end

        // round robin with all four requesters held valid
        do_reset();
        req_data  = DD;
        req_valid = 4'b1111;
        frames    = 0;
        pulses    = 0;
        dcnt      = -1;
        terr_seen = 1'b0;
        for (int c = 0; c < 3000 && frames < 5; c++) begin
            @(negedge clk);
            tx_done = 1'b0;
            if (req_ready != '0) pulses++;
            if (timeout_err) terr_seen = 1'b1;
            if (tx_load) begin
                chk($sformatf("rr%0d.gid", frames), 32'(grant_id),
                    32'(frames % 4));
                chk($sformatf("rr%0d.ready", frames), 32'(req_ready),
                    32'(1 << (frames % 4)));
                chk($sformatf("rr%0d.byte", frames), 32'(tx_byte),
                    32'(8'h10 + frames % 4));
                frames++;
                dcnt = 0;
            end else if (dcnt >= 0) begin
                dcnt++;
                if (dcnt == DONE_DLY) begin
                    tx_done = 1'b1;
                    dcnt    = -1;
                end
            end
        end
        chk("rr.frames", 32'(frames), 32'd5);
        chk("rr.pulses", 32'(pulses), 32'd5);
        chk("rr.terr", 32'(terr_seen), 32'(0));

        // requester 2 withdraws while requester 1 transmits
        do_reset();
        req_data  = DD;
        req_valid = 4'b0110;
        seen2     = 1'b0;
        @(negedge clk);
        chk("wd.gid1", 32'(grant_id), 32'd1);
        chk("wd.ready1", 32'(req_ready), 32'b0010);
        req_valid = 4'b1100;
        repeat (4) begin
            @(negedge clk);
            if (req_ready[2]) seen2 = 1'b1;
        end
        req_valid = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            if (req_ready[2]) seen2 = 1'b1;
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("wd.idle", 32'(busy), 32'h0);
        @(negedge clk);
        if (req_ready[2]) seen2 = 1'b1;
        chk("wd.gid3", 32'(grant_id), 32'd3);
        chk("wd.ready3", 32'(req_ready), 32'b1000);
        chk("wd.byte3", 32'(tx_byte), 32'h13);
        chk("wd.never2", 32'(seen2), 32'h0);

        // reset asserted mid-WAIT
        req_valid = 4'b0000;
        @(negedge clk);
        tx_done   = 1'b1;
        req_valid = 4'b0001;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        chk("rw.load0", 32'(tx_load), 32'h1);
        chk("rw.gid0", 32'(grant_id), 32'h0);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rw.wait", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rw.busy", 32'(busy), 32'h0);
        chk("rw.load", 32'(tx_load), 32'h0);
        chk("rw.gid", 32'(grant_id), 32'h3);
        chk("rw.ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("rw.post.load", 32'(tx_load), 32'h1);
        chk("rw.post.ready", 32'(req_ready), 32'b1000);
        chk("rw.post.gid", 32'(grant_id), 32'h3);
        chk("rw.post.byte", 32'(tx_byte), 32'h13);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rw.post.once", 32'(req_ready), 32'h0);
        chk("rw.post.busy", 32'(busy), 32'h1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // watchdog fires after 16 WAIT cycles without tx_done
        do_reset();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("to.load", 32'(tx_load), 32'h1);
        req_valid = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("to.w%0d.busy", i), 32'(busy), 32'h1);
            chk($sformatf("to.w%0d.terr", i), 32'(timeout_err), 32'h0);
        end
        @(negedge clk);
        chk("to.fire", 32'(timeout_err), 32'h1);
        chk("to.idle", 32'(busy), 32'h0);
        @(negedge clk);
        chk("to.pulse", 32'(timeout_err), 32'h0);

        // tx_done on the limit cycle wins
        req_valid = 4'b0001;
        @(negedge clk);
        chk("tod.load", 32'(tx_load), 32'h1);
        req_valid = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) tx_done = 1'b1;
        end
        @(negedge clk);
        tx_done = 1'b0;
        chk("tod.terr", 32'(timeout_err), 32'h0);
        chk("tod.idle", 32'(busy), 32'h0);
        @(negedge clk);
        chk("tod.terr2", 32'(timeout_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
